// File: rtl/urv_writeback.sv
// urv_writeback: final uRV pipeline stage - waits for memory completion,
// aligns/extends load data, selects the rd source and drives a registered
// register-file write port, with a bus-timeout watchdog.
// Ports:
//   clk_i, rst_i (async, active-low)
//   x_* : X/W pipeline register contents from execute
//   dm_data_l_i, dm_load_done_i, dm_store_done_i : data-memory completion
//   w_stall_req_o, w_load_hazard_o, w_bus_error_o : pipeline control
//   rf_rd_write_o, rf_rd_o, rf_rd_value_o : registered register-file write port
module urv_writeback #(
    parameter int G_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [31:0] x_rd_shifter_i,
    input  logic [31:0] x_rd_multiply_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic        w_stall_req_o,
    output logic        w_load_hazard_o,
    output logic        w_bus_error_o,
    output logic        rf_rd_write_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state, state_next;
    logic [15:0] cnt;
    logic mem_op, done, complete, timeout;
    logic [7:0] lb;
    logic [15:0] lh;
    logic [31:0] load_data, rd_value;
    logic unused;
    // only the lane bits of the address matter here
    assign unused = ^x_dm_addr_i[31:2];
    assign w_load_hazard_o = x_valid_i & x_load_i & ~dm_load_done_i;
    assign lb = x_dm_addr_i[1] ? (x_dm_addr_i[0] ? dm_data_l_i[31:24] : dm_data_l_i[23:16])
                               : (x_dm_addr_i[0] ? dm_data_l_i[15:8]  : dm_data_l_i[7:0]);
    assign lh = x_dm_addr_i[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    always_comb begin
        load_data = 32'h0;
        case (x_fun_i)
            3'b000: load_data = {{24{lb[7]}}, lb};
            3'b100: load_data = {24'h0, lb};
            3'b001: load_data = {{16{lh[15]}}, lh};
            3'b101: load_data = {16'h0, lh};
            3'b010: load_data = dm_data_l_i;
            default: load_data = 32'h0;
        endcase
    end
    assign rd_value = x_rd_source_i == 2'd0 ? x_rd_value_i :
                      x_rd_source_i == 2'd1 ? x_rd_shifter_i :
                      x_rd_source_i == 2'd2 ? x_rd_multiply_i : load_data;
    always_comb begin
        mem_op = x_valid_i & (x_load_i | x_store_i);
        done = x_load_i ? dm_load_done_i : dm_store_done_i;
        state_next = state;
        complete = 1'b0;
        timeout = 1'b0;
        w_stall_req_o = 1'b0;
        if (state == IDLE) begin
            complete = x_valid_i & (~mem_op | done);
            w_stall_req_o = mem_op & ~done;
            if (mem_op & ~done) state_next = WAIT_MEM;
        end else begin
            complete = done;
            // completion wins over timeout on the limit cycle
            timeout = ~done && cnt == 16'(G_TIMEOUT);
            w_stall_req_o = ~done;
            if (done | timeout) state_next = IDLE;
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt <= 16'h0;
            w_bus_error_o <= 1'b0;
            rf_rd_write_o <= 1'b0;
            rf_rd_o <= 5'h0;
            rf_rd_value_o <= 32'h0;
        end else begin
            state <= state_next;
            cnt <= state_next == WAIT_MEM ? (state == IDLE ? 16'h1 : cnt + 16'h1) : 16'h0;
            w_bus_error_o <= timeout;
            rf_rd_write_o <= complete & x_rd_write_i & ~x_store_i & (x_rd_i != 5'h0);
            if (complete) begin
                rf_rd_o <= x_rd_i;
                rf_rd_value_o <= rd_value;
            end
        end
    end
endmodule

// File: tb/tb_urv_writeback.sv
// tb_urv_writeback: directed self-checking bench for urv_writeback (G_TIMEOUT=4).
module tb_urv_writeback;
    logic        clk = 0, rst_n = 0;
    logic        x_valid = 0, x_load = 0, x_store = 0, x_rd_write = 0;
    logic [2:0]  x_fun = 0;
    logic [4:0]  x_rd = 0;
    logic [1:0]  x_src = 0;
    logic [31:0] x_val = 0, x_shf = 0, x_mul = 0, x_addr = 0, dm_data = 0;
    logic        ld_done = 0, st_done = 0;
    logic        stall, hazard, bus_err, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_val;
    int checks = 0, fails = 0;

    urv_writeback #(.G_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .x_valid_i(x_valid), .x_fun_i(x_fun), .x_load_i(x_load), .x_store_i(x_store),
        .x_rd_i(x_rd), .x_rd_write_i(x_rd_write), .x_rd_source_i(x_src),
        .x_rd_value_i(x_val), .x_rd_shifter_i(x_shf), .x_rd_multiply_i(x_mul),
        .x_dm_addr_i(x_addr), .dm_data_l_i(dm_data),
        .dm_load_done_i(ld_done), .dm_store_done_i(st_done),
        .w_stall_req_o(stall), .w_load_hazard_o(hazard), .w_bus_error_o(bus_err),
        .rf_rd_write_o(rf_we), .rf_rd_o(rf_rd), .rf_rd_value_o(rf_val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one memory op whose done arrives after 'late' cycles; reports
    // stall/hazard cycle counts, error pulses and the resulting rf write.
    task automatic mem_op(input logic [2:0] fun, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] data, input int late,
                          output int stalls, output int hz, output int errs,
                          output logic we, output logic [31:0] val);
        stalls = 0; hz = 0; errs = 0;
        x_valid = 1; x_fun = fun; x_load = ld; x_store = st; x_addr = addr;
        x_rd = 5'd7; x_rd_write = 1; x_src = ld ? 2'd3 : 2'd0; dm_data = 32'h0;
        for (int i = 0; i < late; i++) begin
            if (stall) stalls++;
            if (hazard) hz++;
            tick();
            if (bus_err) errs++;
        end
        ld_done = ld; st_done = st; dm_data = data;
        if (stall) stalls++;
        if (hazard) hz++;
        tick();
        if (bus_err) errs++;
        we = rf_we; val = rf_val;
        x_valid = 0; x_load = 0; x_store = 0; ld_done = 0; st_done = 0;
        tick();
        if (bus_err) errs++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        if (rf_we !== 0 || rf_rd !== 0 || rf_val !== 0 || bus_err !== 0 || stall !== 0 || hazard !== 0) begin
            fails++; $display("FAIL reset: we=%b rd=%0d val=%h err=%b stall=%b hz=%b", rf_we, rf_rd, rf_val, bus_err, stall, hazard);
        end
        checks++;
        tick(); rst_n = 1; tick();
    endtask

    task automatic test_alu();
        x_valid = 1; x_src = 0; x_rd = 5; x_rd_write = 1; x_val = 32'h1234;
        x_shf = 32'hAAAA; x_mul = 32'hBBBB;
        #1;
        checks++;
        if (stall !== 0) begin fails++; $display("FAIL alu_stall: got %b want 0", stall); end
        tick();
        x_valid = 0;
        checks++;
        if (rf_we !== 1 || rf_rd !== 5 || rf_val !== 32'h1234) begin
            fails++; $display("FAIL alu_write: we=%b rd=%0d val=%h want 1/5/00001234", rf_we, rf_rd, rf_val);
        end
        tick();
        checks++;
        if (rf_we !== 0) begin fails++; $display("FAIL alu_we_drop: got %b want 0", rf_we); end
        x_valid = 1; x_src = 2; x_rd = 9;
        tick();
        x_valid = 0;
        checks++;
        if (rf_we !== 1 || rf_rd !== 9 || rf_val !== 32'hBBBB) begin
            fails++; $display("FAIL mul_write: we=%b rd=%0d val=%h want 1/9/0000bbbb", rf_we, rf_rd, rf_val);
        end
        tick();
    endtask

    task automatic test_loads();
        int s, h, e; logic we; logic [31:0] v;
        mem_op(3'b000, 1, 0, 32'h103, 32'h80FFFFFF, 2, s, h, e, we, v);
        checks++;
        if (s !== 2 || h !== 2 || e !== 0 || we !== 1 || v !== 32'hFFFFFF80) begin
            fails++; $display("FAIL lb: stall=%0d hz=%0d err=%0d we=%b val=%h want 2/2/0/1/ffffff80", s, h, e, we, v);
        end
        mem_op(3'b100, 1, 0, 32'h103, 32'h80FFFFFF, 2, s, h, e, we, v);
        checks++;
        if (s !== 2 || e !== 0 || we !== 1 || v !== 32'h00000080) begin
            fails++; $display("FAIL lbu: stall=%0d err=%0d we=%b val=%h want 2/0/1/00000080", s, e, we, v);
        end
        mem_op(3'b001, 1, 0, 32'h202, 32'h80010000, 1, s, h, e, we, v);
        checks++;
        if (s !== 1 || we !== 1 || v !== 32'hFFFF8001) begin
            fails++; $display("FAIL lh: stall=%0d we=%b val=%h want 1/1/ffff8001", s, we, v);
        end
        mem_op(3'b101, 1, 0, 32'h202, 32'h80010000, 1, s, h, e, we, v);
        checks++;
        if (s !== 1 || we !== 1 || v !== 32'h00008001) begin
            fails++; $display("FAIL lhu: stall=%0d we=%b val=%h want 1/1/00008001", s, we, v);
        end
        mem_op(3'b000, 1, 0, 32'h101, 32'h12345678, 0, s, h, e, we, v);
        checks++;
        if (s !== 0 || we !== 1 || v !== 32'h00000056) begin
            fails++; $display("FAIL lb_lane1: stall=%0d we=%b val=%h want 0/1/00000056", s, we, v);
        end
        mem_op(3'b010, 1, 0, 32'h300, 32'hDEADBEEF, 0, s, h, e, we, v);
        checks++;
        if (s !== 0 || h !== 0 || we !== 1 || v !== 32'hDEADBEEF) begin
            fails++; $display("FAIL lw: stall=%0d hz=%0d we=%b val=%h want 0/0/1/deadbeef", s, h, we, v);
        end
        mem_op(3'b011, 1, 0, 32'h300, 32'hDEADBEEF, 0, s, h, e, we, v);
        checks++;
        if (we !== 1 || v !== 32'h0) begin
            fails++; $display("FAIL bad_fun: we=%b val=%h want 1/00000000", we, v);
        end
    endtask

    task automatic test_store();
        int s, h, e; logic we; logic [31:0] v;
        mem_op(3'b010, 0, 1, 32'h400, 32'h0, 3, s, h, e, we, v);
        checks++;
        if (s !== 3 || h !== 0 || e !== 0 || we !== 0) begin
            fails++; $display("FAIL store: stall=%0d hz=%0d err=%0d we=%b want 3/0/0/0", s, h, e, we);
        end
    endtask

    task automatic test_timeout();
        int s = 0, ec = 0, wc = 0;
        int e, h; logic we; logic [31:0] v;
        x_valid = 1; x_load = 1; x_fun = 3'b010; x_rd = 4; x_rd_write = 1; x_src = 3;
        for (int i = 0; i < 12; i++) begin
            if (stall) s++;
            tick();
            if (bus_err) begin ec++; x_valid = 0; x_load = 0; end
            if (rf_we) wc++;
        end
        checks++;
        if (s !== 5 || ec !== 1 || wc !== 0) begin
            fails++; $display("FAIL timeout: stall=%0d err=%0d writes=%0d want 5/1/0", s, ec, wc);
        end
        mem_op(3'b010, 1, 0, 32'h500, 32'hCAFEF00D, 4, s, h, e, we, v);
        checks++;
        if (s !== 4 || e !== 0 || we !== 1 || v !== 32'hCAFEF00D) begin
            fails++; $display("FAIL done_on_limit: stall=%0d err=%0d we=%b val=%h want 4/0/1/cafef00d", s, e, we, v);
        end
    endtask

    task automatic test_rd_zero();
        x_valid = 1; x_src = 0; x_rd = 0; x_rd_write = 1; x_val = 32'h55;
        tick();
        x_valid = 0;
        checks++;
        if (rf_we !== 0) begin fails++; $display("FAIL rd_zero: we=%b want 0", rf_we); end
        tick();
    endtask

    task automatic test_reset_wait();
        int wc = 0, ec = 0;
        x_valid = 1; x_load = 1; x_fun = 3'b010; x_rd = 6; x_rd_write = 1; x_src = 3;
        tick(); tick();
        #2;
        rst_n = 0;
        x_valid = 0; x_load = 0;
        #1;
        checks++;
        if (rf_we !== 0 || rf_rd !== 0 || rf_val !== 0 || bus_err !== 0 || stall !== 0) begin
            fails++; $display("FAIL reset_wait: we=%b rd=%0d val=%h err=%b stall=%b want all 0", rf_we, rf_rd, rf_val, bus_err, stall);
        end
        tick(); rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rf_we) wc++;
            if (bus_err) ec++;
        end
        checks++;
        if (wc !== 0 || ec !== 0) begin fails++; $display("FAIL post_reset: writes=%0d err=%0d want 0/0", wc, ec); end
        x_valid = 1; x_src = 0; x_rd = 3; x_val = 32'h77;
        #1;
        checks++;
        if (stall !== 0) begin fails++; $display("FAIL post_reset_idle: stall=%b want 0", stall); end
        tick();
        x_valid = 0;
        checks++;
        if (rf_we !== 1 || rf_rd !== 3 || rf_val !== 32'h77) begin
            fails++; $display("FAIL post_reset_write: we=%b rd=%0d val=%h want 1/3/00000077", rf_we, rf_rd, rf_val);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_store();
        test_timeout();
        test_rd_zero();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/urv_writeback.md
Name: urv_writeback

Overview:
- Final pipeline stage of the uRV core. It consumes the X/W pipeline registers from the execute stage and the data-memory load/store completion signals.
- It waits for memory completion and raises a stall request while waiting. It aligns and sign-extends load data, selects the rd result source, and drives a registered register-file write port.
- A bus-timeout watchdog prevents a hung memory from freezing the core.

Parameters:
- G_TIMEOUT, 255, maximum number of WAIT_MEM cycles before a bus error is declared (1..65535).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-low; all registers cleared on negedge rst_i
- x_valid_i  in  1  X/W register holds a valid instruction
- x_fun_i  in  3  funct3 of the instruction (load width/sign)
- x_load_i  in  1  instruction is a load
- x_store_i  in  1  instruction is a store
- x_rd_i  in  5  destination register index
- x_rd_write_i  in  1  instruction writes rd
- x_rd_source_i  in  2  rd source: 0=x_rd_value_i (ALU/CSR), 1=shifter, 2=multiplier, 3=load data
- x_rd_value_i  in  32  ALU/CSR result
- x_rd_shifter_i  in  32  shifter result
- x_rd_multiply_i  in  32  multiplier result
- x_dm_addr_i  in  32  load/store address
- dm_data_l_i  in  32  load read data, valid when dm_load_done_i=1
- dm_load_done_i  in  1  load completion pulse
- dm_store_done_i  in  1  store completion pulse
- w_stall_req_o  out  1  stall request to pipeline control
- w_load_hazard_o  out  1  load in flight; decode must hold rd-dependent instructions
- w_bus_error_o  out  1  one-cycle pulse on memory timeout
- rf_rd_write_o  out  1  register-file write enable
- rf_rd_o  out  5  register-file write index
- rf_rd_value_o  out  32  register-file write data

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Mem op is defined as x_valid_i & (x_load_i | x_store_i).
- Done is dm_load_done_i for loads and dm_store_done_i for stores.
- FSM states are IDLE and WAIT_MEM.

IDLE:
- Non-mem valid instruction: completes this cycle.
- Mem op with done=1: completes this cycle.
- Mem op with done=0: go to WAIT_MEM, counter <= 1.

WAIT_MEM:
- Upstream holds x_* inputs stable throughout.
- done=1: complete and return to IDLE.
- Otherwise, if counter == G_TIMEOUT: pulse w_bus_error_o, discard the instruction (no rf write), return to IDLE.
- Otherwise: counter+1.
- Completion has priority over timeout when both occur in the same cycle.

Stall and hazard outputs:
- w_stall_req_o is combinational: (mem op & !done) in IDLE, or !done in WAIT_MEM. It deasserts in the cycle done arrives.
- w_load_hazard_o is combinational: (x_valid_i & x_load_i) & !dm_load_done_i.

Load data extraction:
- Byte lane = x_dm_addr_i[1:0]; halfword lane = x_dm_addr_i[1].
- LB (000): sign-extend the selected byte.
- LBU (100): zero-extend the selected byte.
- LH (001): sign-extend the selected halfword.
- LHU (101): zero-extend the selected halfword.
- LW (010): full word.
- Other funct3 values: 0.
- Little-endian: lane 0 = bits [7:0].

Register-file write:
- On completion, the write is registered: rf_rd_write_o <= x_rd_write_i & (x_rd_i != 0).
- rf_rd_o and rf_rd_value_o are updated in the same cycle.
- The write appears 1 cycle after completion.
- In all other cycles rf_rd_write_o <= 0; rf_rd_o and rf_rd_value_o hold their last value.
- Stores never write rd, even if x_rd_write_i is set.

Reset and invalid input:
- Reset asserted in WAIT_MEM: return to IDLE, no write, no error pulse.
- x_valid_i=0 in IDLE: no action, no stall.

Test Plan:
- ALU write: x_rd_source_i=0, x_rd_i=5, x_rd_value_i=0x1234 -> next cycle rf_rd_write_o=1, rf_rd_o=5, rf_rd_value_o=0x1234; w_stall_req_o=0 throughout.
- LB with late done: addr=0x...3, done 2 cycles late, data=0x80FFFFFF -> stall high for 2 cycles, then rf_rd_value_o=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LH at addr[1]=1 with data=0x8001_0000 -> 0xFFFF8001; LHU -> 0x00008001; LW with same-cycle done -> no stall, full word written.
- Store with x_rd_write_i=1 and done after 3 cycles -> stall for 3 cycles, rf_rd_write_o stays 0.
- Timeout with G_TIMEOUT=4 and no done -> w_bus_error_o pulses exactly once, no rf write, FSM returns to IDLE. Done arriving on the limit cycle instead -> normal completion, no error.
- Write to rd=0 -> rf_rd_write_o=0. Reset asserted during WAIT_MEM -> all outputs 0 immediately, no write after release.
